// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and arbitrates raw push-button
// pads into a clean zero-or-one-hot level for the game controller, plus
// press/release strobes and a multi-button conflict flag.
module btn_conditioner #(
  parameter int NUM_BTN     = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ticks_per_milli,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               conflict
);

  localparam int         IDX_W     = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam logic [7:0] STAB_LAST = 8'(DEBOUNCE_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD,
    S_WAIT_ALL,
    S_CONFLICT
  } state_t;

  // ---------------------------------------------------------------------------
  // Millisecond time base
  // ---------------------------------------------------------------------------
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic        ms_tick_q, ms_tick_d;

  // Free-running counter; >= (not ==) so lowering ticks_per_milli mid-run
  // wraps on the next edge instead of running through all 65536 states.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 16'd1;
    ms_tick_d  = 1'b0;
    if (tick_cnt_q >= ticks_per_milli) begin
      tick_cnt_d = '0;
      ms_tick_d  = 1'b1;
    end
  end

  // Tick counter and registered one-cycle millisecond strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      ms_tick_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      ms_tick_q  <= ms_tick_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync_d [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync;

  // Shift the raw pads down the metastability chain.
  always_comb begin
    sync_d[0] = btn_raw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] deb_q, deb_d;
  logic [7:0]         stab_q [NUM_BTN];
  logic [7:0]         stab_d [NUM_BTN];
  logic [NUM_BTN-1:0] mismatch;
  logic [NUM_BTN-1:0] stab_full;

  // Per-button helper flags: differs from accepted level / interval complete.
  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_flag
      assign mismatch[gi]  = sync[gi] ^ deb_q[gi];
      assign stab_full[gi] = (stab_q[gi] == STAB_LAST);
    end
  endgenerate

  // A new level is accepted only after DEBOUNCE_MS consecutive ticks of
  // disagreement; any return to the accepted level restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      stab_d[i] = stab_q[i];
      if (!mismatch[i]) begin
        stab_d[i] = '0;
      end else if (ms_tick_q) begin
        if (stab_full[i]) begin
          deb_d[i]  = sync[i];
          stab_d[i] = '0;
        end else begin
          stab_d[i] = stab_q[i] + 8'd1;
        end
      end
    end
  end

  // Debounced level and stability counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        stab_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        stab_q[i] <= stab_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_BTN-1:0] btn_q, btn_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic               conflict_q, conflict_d;

  logic               deb_any;
  logic               deb_multi;
  logic [IDX_W-1:0]   deb_enc;
  logic [NUM_BTN-1:0] held_mask;

  // Classify the debounced vector: any bit, more than one bit, and the
  // index of the set bit (meaningful only when exactly one is set).
  always_comb begin
    deb_any   = (deb_q != '0);
    deb_multi = ((deb_q & (deb_q - NUM_BTN'(1))) != '0);
    deb_enc   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (deb_q[i]) begin
        deb_enc = IDX_W'(i);
      end
    end
  end

  assign held_mask = NUM_BTN'(1) << idx_q;

  // Next-state and registered-output logic; strobes default low.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    btn_d     = btn_q;
    press_d   = '0;
    release_d = '0;
    unique case (state_q)
      S_IDLE: begin
        btn_d = '0;
        if (deb_multi) begin
          state_d = S_CONFLICT;
        end else if (deb_any) begin
          idx_d   = deb_enc;
          btn_d   = NUM_BTN'(1) << deb_enc;
          press_d = NUM_BTN'(1) << deb_enc;
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        btn_d = held_mask;
        if ((deb_q & held_mask) == '0) begin
          btn_d     = '0;
          release_d = held_mask;
          // Another button still down must not turn into a fresh press.
          state_d   = deb_any ? S_WAIT_ALL : S_IDLE;
        end
      end
      S_WAIT_ALL: begin
        btn_d = '0;
        if (!deb_any) begin
          state_d = S_IDLE;
        end
      end
      S_CONFLICT: begin
        btn_d = '0;
        if (!deb_any) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        btn_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    conflict_d = (state_d == S_CONFLICT);
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      btn_q      <= '0;
      press_q    <= '0;
      release_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      btn_q      <= btn_d;
      press_q    <= press_d;
      release_q  <= release_d;
      conflict_q <= conflict_d;
    end
  end

  assign btn         = btn_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: table of level steps plus
// hand-written latency, bounce, reset and time-base sequences.
module tb_btn_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tpm;
  logic [3:0]  raw;
  logic [3:0]  btn;
  logic [3:0]  bp;
  logic [3:0]  br;
  logic        conflict;

  always #5 clk = ~clk;

  btn_conditioner #(
    .NUM_BTN    (4),
    .DEBOUNCE_MS(3),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ticks_per_milli(tpm),
    .btn_raw        (raw),
    .btn            (btn),
    .btn_press      (bp),
    .btn_release    (br),
    .conflict       (conflict)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         press_cnt;
  int         rel_cnt;
  logic [3:0] press_or;
  logic [3:0] rel_or;
  logic [3:0] btn_seen;
  logic       conflict_seen;

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] exp_btn;
    logic       exp_conflict;
    int         exp_press;
    logic [3:0] exp_press_mask;
    int         exp_rel;
    logic [3:0] exp_rel_mask;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic clear_acc();
    press_cnt     = 0;
    rel_cnt       = 0;
    press_or      = '0;
    rel_or        = '0;
    btn_seen      = '0;
    conflict_seen = 1'b0;
  endtask

  // One clock: sample at the falling edge, accumulate strobes, check invariants.
  task automatic cyc();
    @(negedge clk);
    if (bp != 4'b0000) press_cnt++;
    if (br != 4'b0000) rel_cnt++;
    press_or      = press_or | bp;
    rel_or        = rel_or | br;
    btn_seen      = btn_seen | btn;
    conflict_seen = conflict_seen | conflict;
    check("btn_onehot", 32'($countones(btn) <= 1), 32'd1);
    check("strobe_exclusive", 32'((bp != 0) && (br != 0)), 32'd0);
  endtask

  task automatic wait_btn(input logic [3:0] want, input int limit, output int lat);
    lat = 0;
    while (btn !== want && lat < limit) begin
      cyc();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int n;

    vecs[0]  = '{4'b0100, 50, 4'b0100, 1'b0, 1, 4'b0100, 0, 4'b0000};
    vecs[1]  = '{4'b0000, 50, 4'b0000, 1'b0, 0, 4'b0000, 1, 4'b0100};
    vecs[2]  = '{4'b0001, 50, 4'b0001, 1'b0, 1, 4'b0001, 0, 4'b0000};
    vecs[3]  = '{4'b1001, 50, 4'b0001, 1'b0, 0, 4'b0000, 0, 4'b0000};
    vecs[4]  = '{4'b1000, 50, 4'b0000, 1'b0, 0, 4'b0000, 1, 4'b0001};
    vecs[5]  = '{4'b0000, 50, 4'b0000, 1'b0, 0, 4'b0000, 0, 4'b0000};
    vecs[6]  = '{4'b0011, 50, 4'b0000, 1'b1, 0, 4'b0000, 0, 4'b0000};
    vecs[7]  = '{4'b0000, 50, 4'b0000, 1'b0, 0, 4'b0000, 0, 4'b0000};
    vecs[8]  = '{4'b0100, 50, 4'b0100, 1'b0, 1, 4'b0100, 0, 4'b0000};
    vecs[9]  = '{4'b0000, 50, 4'b0000, 1'b0, 0, 4'b0000, 1, 4'b0100};
    vecs[10] = '{4'b0010, 50, 4'b0010, 1'b0, 1, 4'b0010, 0, 4'b0000};
    vecs[11] = '{4'b0110, 50, 4'b0010, 1'b0, 0, 4'b0000, 0, 4'b0000};
    vecs[12] = '{4'b0100, 50, 4'b0000, 1'b0, 0, 4'b0000, 1, 4'b0010};
    vecs[13] = '{4'b0110, 50, 4'b0000, 1'b0, 0, 4'b0000, 0, 4'b0000};
    vecs[14] = '{4'b0000, 50, 4'b0000, 1'b0, 0, 4'b0000, 0, 4'b0000};

    // Reset state.
    rst = 1'b1;
    tpm = 16'd9;
    raw = 4'b0000;
    clear_acc();
    repeat (3) @(negedge clk);
    check("rst_btn", 32'(btn), 32'h0);
    check("rst_press", 32'(bp), 32'h0);
    check("rst_release", 32'(br), 32'h0);
    check("rst_conflict", 32'(conflict), 32'h0);
    check("rst_tick_cnt", 32'(dut.tick_cnt_q), 32'h0);
    rst = 1'b0;
    repeat (3) cyc();

    // Clean press and release latency.
    clear_acc();
    raw = 4'b0100;
    wait_btn(4'b0100, 60, lat);
    $display("clean press: latency %0d cycles, btn=%b", lat, btn);
    check_range("press_latency", lat, 23, 34);
    repeat (20) cyc();
    check("clean_press_cnt", 32'(press_cnt), 32'd1);
    check("clean_conflict", 32'(conflict_seen), 32'd0);
    clear_acc();
    raw = 4'b0000;
    wait_btn(4'b0000, 60, lat);
    $display("clean release: latency %0d cycles, btn=%b", lat, btn);
    check_range("release_latency", lat, 23, 34);
    repeat (20) cyc();
    check("clean_rel_cnt", 32'(rel_cnt), 32'd1);
    check("clean_rel_mask", 32'(rel_or), 32'h4);

    // Table of level steps.
    for (int v = 0; v < 15; v++) begin
      clear_acc();
      raw = vecs[v].raw;
      repeat (vecs[v].hold) cyc();
      $display("vec %0d raw=%b btn=%b conflict=%b press=%0d/%b release=%0d/%b",
               v, raw, btn, conflict, press_cnt, press_or, rel_cnt, rel_or);
      check($sformatf("vec%0d_btn", v), 32'(btn), 32'(vecs[v].exp_btn));
      check($sformatf("vec%0d_conflict", v), 32'(conflict), 32'(vecs[v].exp_conflict));
      check($sformatf("vec%0d_press_cnt", v), 32'(press_cnt), 32'(vecs[v].exp_press));
      check($sformatf("vec%0d_press_mask", v), 32'(press_or), 32'(vecs[v].exp_press_mask));
      check($sformatf("vec%0d_rel_cnt", v), 32'(rel_cnt), 32'(vecs[v].exp_rel));
      check($sformatf("vec%0d_rel_mask", v), 32'(rel_or), 32'(vecs[v].exp_rel_mask));
    end

    // Bounce: bit1 toggles every 7 cycles, then holds high.
    clear_acc();
    for (int i = 0; i < 60; i++) begin
      raw = (((i / 7) % 2) == 0) ? 4'b0010 : 4'b0000;
      cyc();
    end
    $display("bounce: btn seen during bouncing=%b, presses=%0d", btn_seen, press_cnt);
    check("bounce_quiet_btn", 32'(btn_seen), 32'h0);
    check("bounce_quiet_press", 32'(press_cnt), 32'd0);
    wait_btn(4'b0010, 60, lat);
    $display("bounce: settled btn=%b after %0d cycles", btn, lat);
    check_range("bounce_latency", lat, 19, 30);
    repeat (10) cyc();
    check("bounce_press_cnt", 32'(press_cnt), 32'd1);
    check("bounce_press_mask", 32'(press_or), 32'h2);
    raw = 4'b0000;
    repeat (50) cyc();
    check("bounce_rel_cnt", 32'(rel_cnt), 32'd1);
    check("bounce_btn_after", 32'(btn), 32'h0);

    // Asynchronous reset in the middle of a hold.
    clear_acc();
    raw = 4'b1000;
    repeat (50) cyc();
    check("hold_btn", 32'(btn), 32'h8);
    clear_acc();
    #2 rst = 1'b1;
    #1;
    $display("reset mid-hold: btn=%b release=%b", btn, br);
    check("async_rst_btn", 32'(btn), 32'h0);
    check("async_rst_release", 32'(br), 32'h0);
    repeat (3) cyc();
    #2 rst = 1'b0;
    wait_btn(4'b1000, 60, lat);
    $display("reset mid-hold: re-accepted after %0d cycles", lat);
    check_range("reaccept_latency", lat, 23, 34);
    repeat (5) cyc();
    check("reaccept_press_cnt", 32'(press_cnt), 32'd1);
    check("reaccept_press_mask", 32'(press_or), 32'h8);
    check("reaccept_no_release", 32'(rel_cnt), 32'd0);
    raw = 4'b0000;
    repeat (50) cyc();

    // Millisecond time base: period, then lowering the threshold mid-count.
    n = 0;
    while (dut.ms_tick_q !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    n = 1;
    while (dut.ms_tick_q !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    $display("tick period with tpm=9: %0d cycles", n);
    check("tick_period_10", 32'(n), 32'd10);
    n = 0;
    while (dut.tick_cnt_q !== 16'd7 && n < 20) begin
      cyc();
      n++;
    end
    check("tick_cnt_reached_7", 32'(dut.tick_cnt_q), 32'd7);
    tpm = 16'd2;
    cyc();
    $display("tpm 9->2 at tick_cnt=7: ms_tick=%b tick_cnt=%0d", dut.ms_tick_q, dut.tick_cnt_q);
    check("tick_after_lower", 32'(dut.ms_tick_q), 32'd1);
    check("tick_cnt_no_wrap", 32'(dut.tick_cnt_q), 32'd0);
    cyc();
    n = 1;
    while (dut.ms_tick_q !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("tick_period_3", 32'(n), 32'd3);

    // Fast tick: one millisecond per cycle.
    tpm = 16'd0;
    repeat (3) cyc();
    clear_acc();
    raw = 4'b0001;
    wait_btn(4'b0001, 20, lat);
    $display("fast tick press: latency %0d cycles", lat);
    check_range("fast_press_latency", lat, 5, 7);
    raw = 4'b0000;
    wait_btn(4'b0000, 20, lat);
    $display("fast tick release: latency %0d cycles", lat);
    check_range("fast_release_latency", lat, 5, 7);
    repeat (5) cyc();
    check("fast_press_cnt", 32'(press_cnt), 32'd1);
    check("fast_rel_cnt", 32'(rel_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
